status_clear_ctrl: RTL and testbench



---
 rtl/status_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/status_clear_ctrl.sv | 132 +++++++++++++
 tb/tb_status_clear_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/status_pkg.sv
// Shared constants and state encoding for the sticky-status clear controller.
package status_pkg;

    localparam int unsigned STATUS_W = 13;
    localparam int unsigned CLR_LAT  = 3;

    localparam int unsigned BIT_RX_OVF     = 0;
    localparam int unsigned BIT_TX_UNF     = 2;
    localparam int unsigned BIT_CRC_ERR    = 3;
    localparam int unsigned BIT_FRAME_ERR  = 5;
    localparam int unsigned BIT_PARITY_ERR = 6;
    localparam int unsigned BIT_TIMEOUT    = 9;
    localparam int unsigned BIT_FATAL      = 12;

    localparam logic [STATUS_W-1:0] STICKY_MASK = STATUS_W'(
        (1 << BIT_RX_OVF) | (1 << BIT_TX_UNF) | (1 << BIT_CRC_ERR) |
        (1 << BIT_FRAME_ERR) | (1 << BIT_PARITY_ERR) | (1 << BIT_TIMEOUT) |
        (1 << BIT_FATAL));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2,
        ACK     = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick; search starts one past the last grant.
module rr_arbiter #(
    parameter  int unsigned NREQ  = 2,
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDX_W'((32'(last_gnt) + 32'd1 + i) % NREQ);
            if (!any && req[cand]) begin
                gnt_idx = cand;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/status_clear_ctrl.sv
// Clear-on-read sequencer for the sticky status register: arbitrates requesters,
// snapshots sticky bits, drives the clear protocol and reports events lost meanwhile.
module status_clear_ctrl #(
    parameter  int unsigned            NREQ        = 2,
    parameter  int unsigned            STATUS_W    = status_pkg::STATUS_W,
    parameter  logic [STATUS_W-1:0]    STICKY_MASK = STATUS_W'(status_pkg::STICKY_MASK),
    parameter  int unsigned            CLR_LAT     = status_pkg::CLR_LAT,
    localparam int unsigned            IDX_W       = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int unsigned            CNT_W       = (CLR_LAT > 1) ? $clog2(CLR_LAT) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     ack,
    input  logic [STATUS_W-1:0] status_in,
    input  logic [STATUS_W-1:0] ev_in,
    input  logic [STATUS_W-1:0] irq_mask,
    output logic                clear,
    output logic [STATUS_W-1:0] snapshot,
    output logic [STATUS_W-1:0] missed,
    output logic                snap_valid,
    output logic                busy,
    output logic                irq
);
    import status_pkg::*;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]    last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STATUS_W-1:0] snapshot_q, snapshot_d;
    logic [STATUS_W-1:0] missed_q, missed_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                clear_q, clear_d;
    logic                snap_valid_q, snap_valid_d;
    logic                busy_q, busy_d;
    logic                irq_q, irq_d;

    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req      (req),
        .last_gnt (last_gnt_q),
        .gnt_idx  (arb_idx),
        .any      (arb_any)
    );

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        snapshot_d = snapshot_q;
        missed_d   = missed_q;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d    = CAPTURE;
                    gnt_idx_d  = arb_idx;
                    last_gnt_d = arb_idx;
                end
            end
            CAPTURE: begin
                state_d    = HOLD;
                cnt_d      = CNT_W'(CLR_LAT - 1);
                snapshot_d = status_in & STICKY_MASK;
                missed_d   = ev_in & STICKY_MASK;
            end
            HOLD: begin
                // Events here land while the register is still clearing, so they are lost.
                missed_d = missed_q | (ev_in & STICKY_MASK);
                if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the flops line up with the state.
        clear_d      = (state_d == CAPTURE);
        busy_d       = (state_d != IDLE);
        snap_valid_d = (state_d == ACK);
        ack_d        = (state_d == ACK) ? (NREQ'(1) << gnt_idx_d) : '0;
        irq_d        = (state_d == IDLE) && (|(status_in & STICKY_MASK & irq_mask));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_idx_q    <= '0;
            last_gnt_q   <= IDX_W'(NREQ - 1);
            cnt_q        <= '0;
            snapshot_q   <= '0;
            missed_q     <= '0;
            ack_q        <= '0;
            clear_q      <= 1'b0;
            snap_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_idx_q    <= gnt_idx_d;
            last_gnt_q   <= last_gnt_d;
            cnt_q        <= cnt_d;
            snapshot_q   <= snapshot_d;
            missed_q     <= missed_d;
            ack_q        <= ack_d;
            clear_q      <= clear_d;
            snap_valid_q <= snap_valid_d;
            busy_q       <= busy_d;
            irq_q        <= irq_d;
        end
    end

    assign ack        = ack_q;
    assign clear      = clear_q;
    assign snapshot   = snapshot_q;
    assign missed     = missed_q;
    assign snap_valid = snap_valid_q;
    assign busy       = busy_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_status_clear_ctrl.sv
// Bench for status_clear_ctrl: per-scenario tasks plus an ack scoreboard.
module tb_status_clear_ctrl;

    localparam int unsigned NREQ = 2;
    localparam int unsigned SW   = 13;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic [SW-1:0]   status_in;
    logic [SW-1:0]   ev_in;
    logic [SW-1:0]   irq_mask;
    logic            clear;
    logic [SW-1:0]   snapshot;
    logic [SW-1:0]   missed;
    logic            snap_valid;
    logic            busy;
    logic            irq;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NREQ-1:0] ack;
        logic [SW-1:0]   snap;
        logic [SW-1:0]   missed;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;

    status_clear_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .status_in  (status_in),
        .ev_in      (ev_in),
        .irq_mask   (irq_mask),
        .clear      (clear),
        .snapshot   (snapshot),
        .missed     (missed),
        .snap_valid (snap_valid),
        .busy       (busy),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Scoreboard: every completion must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (snap_valid || (ack != '0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: ack=%b snap_valid=%b with nothing expected", ack, snap_valid);
            end else begin
                exp_e = exp_q.pop_front();
                if ({ack, snapshot, missed, snap_valid} !== {exp_e.ack, exp_e.snap, exp_e.missed, 1'b1}) begin
                    errors++;
                    $display("FAIL sb_ack: got ack=%b snap=%h missed=%h sv=%b, expected ack=%b snap=%h missed=%h sv=1",
                             ack, snapshot, missed, snap_valid, exp_e.ack, exp_e.snap, exp_e.missed);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; ev_in = '0; irq_mask = '0; status_in = 13'h1FFF;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({ack, clear, snap_valid, busy, irq} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ack=%b clear=%b sv=%b busy=%b irq=%b, expected all 0",
                     ack, clear, snap_valid, busy, irq);
        end
        checks++;
        if ({snapshot, missed} !== 26'b0) begin
            errors++;
            $display("FAIL reset_data: got snapshot=%h missed=%h, expected 0", snapshot, missed);
        end
        irq_mask = 13'h0001;
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_mask_bit0: got %b expected 1", irq); end
        irq_mask = 13'h0002;
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_nonsticky: got %b expected 0", irq); end
        irq_mask = '0;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] exp_ack;
        status_in = 13'h126D;
        req = 2'b01;
        exp_q.push_back('{ack: 2'b01, snap: 13'h126D, missed: 13'h0000});
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_ack = (k == 5) ? 2'b01 : 2'b00;
            checks++;
            if (clear !== (k == 1)) begin
                errors++; $display("FAIL single_clear: cycle t+%0d got %b expected %b", k, clear, (k == 1));
            end
            checks++;
            if (ack !== exp_ack || busy !== (k <= 5)) begin
                errors++;
                $display("FAIL single_ack_busy: cycle t+%0d got ack=%b busy=%b expected ack=%b busy=%b",
                         k, ack, busy, exp_ack, (k <= 5));
            end
            if (k == 5) req = '0;
        end
    endtask

    task automatic test_missed();
        status_in = '0;
        req = 2'b01;
        exp_q.push_back('{ack: 2'b01, snap: 13'h0000, missed: 13'h0208});
        for (int k = 1; k <= 7; k++) begin
            tick();
            case (k)
                1: ev_in = 13'h0008;
                2: ev_in = 13'h0002;
                4: ev_in = 13'h0200;
                5: ev_in = 13'h0020;
                default: ev_in = '0;
            endcase
            if (k == 5) req = '0;
        end
        checks++;
        if (missed !== 13'h0208 || snapshot !== 13'h0000) begin
            errors++;
            $display("FAIL missed_hold: got missed=%h snap=%h expected missed=0208 snap=0000", missed, snapshot);
        end
    endtask

    task automatic test_back_to_back();
        int clears;
        logic [NREQ-1:0] exp_ack;
        rst = 1'b1; req = '0; ev_in = '0;
        tick();
        rst = 1'b0;
        status_in = 13'h1FFF;
        req = 2'b11;
        exp_q.push_back('{ack: 2'b01, snap: 13'h126D, missed: 13'h0000});
        exp_q.push_back('{ack: 2'b10, snap: 13'h126D, missed: 13'h0000});
        exp_q.push_back('{ack: 2'b01, snap: 13'h126D, missed: 13'h0000});
        clears = 0;
        for (int k = 1; k <= 19; k++) begin
            tick();
            exp_ack = (k == 5 || k == 17) ? 2'b01 : (k == 11) ? 2'b10 : 2'b00;
            if (clear) clears++;
            checks++;
            if (clear !== (k == 1 || k == 7 || k == 13) || ack !== exp_ack) begin
                errors++;
                $display("FAIL b2b: cycle t+%0d got clear=%b ack=%b expected clear=%b ack=%b",
                         k, clear, ack, (k == 1 || k == 7 || k == 13), exp_ack);
            end
            if (k == 17) req = '0;
        end
        checks++;
        if (clears != 3) begin errors++; $display("FAIL b2b_clear_count: got %0d expected 3", clears); end
    endtask

    task automatic test_reset_mid();
        status_in = 13'h0040;
        req = 2'b01;
        for (int k = 1; k <= 3; k++) tick();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (ack !== '0 || clear !== 1'b0 || busy !== 1'b0 || snap_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid: step %0d got ack=%b clear=%b busy=%b sv=%b expected all 0",
                         k, ack, clear, busy, snap_valid);
            end
            tick();
        end
        status_in = 13'h1001;
        req = 2'b10;
        exp_q.push_back('{ack: 2'b10, snap: 13'h1001, missed: 13'h0000});
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (ack !== ((k == 5) ? 2'b10 : 2'b00) || clear !== (k == 1)) begin
                errors++;
                $display("FAIL rst_fresh: cycle t+%0d got ack=%b clear=%b", k, ack, clear);
            end
            if (k == 5) req = '0;
        end
    endtask

    task automatic test_irq();
        status_in = 13'h1000;
        irq_mask  = 13'h1000;
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_pre: got %b expected 1", irq); end
        for (int round = 0; round < 2; round++) begin
            req = 2'b01;
            exp_q.push_back('{ack: 2'b01, snap: 13'h1000, missed: 13'h0000});
            for (int k = 1; k <= 6; k++) begin
                tick();
                checks++;
                if (irq !== ((k == 6) && (round == 1))) begin
                    errors++;
                    $display("FAIL irq_seq: round %0d cycle t+%0d got %b expected %b",
                             round, k, irq, ((k == 6) && (round == 1)));
                end
                if (k == 5) begin
                    req = '0;
                    if (round == 0) status_in = '0;
                end
            end
            status_in = 13'h1000;
            tick();
        end
        irq_mask = '0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        req = '0;
        status_in = '0;
        ev_in = '0;
        irq_mask = '0;
        test_reset();
        test_single();
        test_missed();
        test_back_to_back();
        test_reset_mid();
        test_irq();
        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected acks never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
